// File: rtl/loop_nest_seq.sv
// Runtime sequencer for the two-level loop nest: emits (k, l, 2^k + l) tuples
// as a valid/ready stream, k = 0..NumOuter-1, l = 0..2^k-1.
module loop_nest_seq #(
  parameter int NumOuter = 3,
  parameter int OuterW   = (NumOuter > 1) ? $clog2(NumOuter) : 1,
  parameter int InnerW   = (NumOuter > 1) ? NumOuter - 1 : 1,
  parameter int ValueW   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              clear_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [OuterW-1:0] outer_o,
  output logic [InnerW-1:0] inner_o,
  output logic [ValueW-1:0] value_o,
  output logic              last_inner_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  if (NumOuter < 1 || NumOuter > 31) begin : g_bad_outer
    $error("loop_nest_seq: NumOuter must be in 1..31");
  end
  if (ValueW < NumOuter + 1) begin : g_bad_value
    $error("loop_nest_seq: ValueW must be at least NumOuter+1");
  end

  localparam logic [ValueW-1:0] FinalValue = ValueW'((64'd1 << NumOuter) - 64'd1);

  typedef enum logic [1:0] {Idle, Run, Done} state_t;
  state_t state;

  // value = 2^k + l, so l == 2^k-1 exactly when value+1 is a power of two.
  logic [ValueW-1:0] value_nxt;
  logic [ValueW-1:0] value_nxt_inc;
  logic              last_inner_nxt;
  logic              last_nxt;

  assign value_nxt      = value_o + ValueW'(1);
  assign value_nxt_inc  = value_nxt + ValueW'(1);
  assign last_inner_nxt = ((value_nxt & value_nxt_inc) == '0);
  assign last_nxt       = (value_nxt == FinalValue);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state        <= Idle;
      valid_o      <= 1'b0;
      outer_o      <= '0;
      inner_o      <= '0;
      value_o      <= '0;
      last_inner_o <= 1'b0;
      last_o       <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      case (state)
        Idle: begin
          if (start_i) begin
            state        <= Run;
            valid_o      <= 1'b1;
            busy_o       <= 1'b1;
            outer_o      <= '0;
            inner_o      <= '0;
            value_o      <= ValueW'(1);
            last_inner_o <= 1'b1;
            last_o       <= (NumOuter == 1);
          end
        end
        Run: begin
          if (ready_i) begin
            if (last_o) begin
              state        <= Done;
              valid_o      <= 1'b0;
              done_o       <= 1'b1;
              outer_o      <= '0;
              inner_o      <= '0;
              value_o      <= '0;
              last_inner_o <= 1'b0;
              last_o       <= 1'b0;
            end else begin
              value_o      <= value_nxt;
              last_inner_o <= last_inner_nxt;
              last_o       <= last_nxt;
              if (last_inner_o) begin
                outer_o <= outer_o + OuterW'(1);
                inner_o <= '0;
              end else begin
                inner_o <= inner_o + InnerW'(1);
              end
            end
          end
        end
        Done: begin
          state  <= Idle;
          done_o <= 1'b0;
          busy_o <= 1'b0;
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_nest_seq.sv
// Randomized bench for loop_nest_seq: three instances (NumOuter = 3, 1, 5)
// checked against a queue of tuples built directly from the loop-nest definition.
module tb_loop_nest_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clear;
  logic       ready;
  logic [2:0] start;

  logic        a_valid, a_li, a_last, a_busy, a_done;
  logic [1:0]  a_outer;
  logic [1:0]  a_inner;
  logic [31:0] a_value;
  logic        b_valid, b_li, b_last, b_busy, b_done;
  logic [0:0]  b_outer;
  logic [0:0]  b_inner;
  logic [31:0] b_value;
  logic        c_valid, c_li, c_last, c_busy, c_done;
  logic [2:0]  c_outer;
  logic [3:0]  c_inner;
  logic [31:0] c_value;

  loop_nest_seq #(.NumOuter(3)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .clear_i(clear),
    .valid_o(a_valid), .ready_i(ready), .outer_o(a_outer), .inner_o(a_inner),
    .value_o(a_value), .last_inner_o(a_li), .last_o(a_last), .busy_o(a_busy),
    .done_o(a_done));

  loop_nest_seq #(.NumOuter(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .clear_i(clear),
    .valid_o(b_valid), .ready_i(ready), .outer_o(b_outer), .inner_o(b_inner),
    .value_o(b_value), .last_inner_o(b_li), .last_o(b_last), .busy_o(b_busy),
    .done_o(b_done));

  loop_nest_seq #(.NumOuter(5)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .clear_i(clear),
    .valid_o(c_valid), .ready_i(ready), .outer_o(c_outer), .inner_o(c_inner),
    .value_o(c_value), .last_inner_o(c_li), .last_o(c_last), .busy_o(c_busy),
    .done_o(c_done));

  int sel;
  logic        m_valid, m_li, m_last, m_busy, m_done;
  logic [31:0] m_outer, m_inner, m_value;

  always_comb begin
    m_valid = 1'b0; m_li = 1'b0; m_last = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    m_outer = '0; m_inner = '0; m_value = '0;
    case (sel)
      0: begin
        m_valid = a_valid; m_li = a_li; m_last = a_last; m_busy = a_busy; m_done = a_done;
        m_outer = 32'(a_outer); m_inner = 32'(a_inner); m_value = a_value;
      end
      1: begin
        m_valid = b_valid; m_li = b_li; m_last = b_last; m_busy = b_busy; m_done = b_done;
        m_outer = 32'(b_outer); m_inner = 32'(b_inner); m_value = b_value;
      end
      default: begin
        m_valid = c_valid; m_li = c_li; m_last = c_last; m_busy = c_busy; m_done = c_done;
        m_outer = 32'(c_outer); m_inner = 32'(c_inner); m_value = c_value;
      end
    endcase
  end

  typedef struct {
    int k;
    int l;
    int v;
    bit li;
    bit last;
  } tup_t;

  tup_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic int num_outer(input int s);
    return (s == 0) ? 3 : (s == 1) ? 1 : 5;
  endfunction

  // Expected stream straight from the nest: for k, for l < 2^k, value 2^k + l.
  task automatic build(input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      for (int l = 0; l < (1 << k); l++) begin
        tup_t t;
        t.k    = k;
        t.l    = l;
        t.v    = (1 << k) + l;
        t.li   = (l == (1 << k) - 1);
        t.last = (k == n - 1) && (l == (1 << k) - 1);
        exp_q.push_back(t);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(m_valid), 0);
    check({tag, "_outer"}, 64'(m_outer), 0);
    check({tag, "_inner"}, 64'(m_inner), 0);
    check({tag, "_value"}, 64'(m_value), 0);
    check({tag, "_li"},    64'(m_li),    0);
    check({tag, "_last"},  64'(m_last),  0);
    check({tag, "_busy"},  64'(m_busy),  0);
    check({tag, "_done"},  64'(m_done),  0);
  endtask

  task automatic check_beat(input int idx);
    check("beat_valid", 64'(m_valid), 1);
    check("beat_outer", 64'(m_outer), 64'(exp_q[idx].k));
    check("beat_inner", 64'(m_inner), 64'(exp_q[idx].l));
    check("beat_value", 64'(m_value), 64'(exp_q[idx].v));
    check("beat_li",    64'(m_li),    64'(exp_q[idx].li));
    check("beat_last",  64'(m_last),  64'(exp_q[idx].last));
    check("beat_done",  64'(m_done),  0);
  endtask

  // Drive one sequence; clear_after > 0 aborts after that many handshakes.
  task automatic run_seq(input int s, input int pct, input int clear_after, input bit poke);
    int idx  = 0;
    int cyc  = 0;
    int stop;
    sel = s;
    build(num_outer(s));
    stop = (clear_after > 0) ? clear_after : exp_q.size();
    @(negedge clk);
    check("pre_busy", 64'(m_busy), 0);
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    check("start_busy", 64'(m_busy), 1);
    while (idx < stop && cyc < 2000) begin
      cyc++;
      check_beat(idx);
      ready = ($urandom_range(99) < pct);
      if (poke) start[s] = ($urandom_range(3) == 0);
      if (ready) idx++;
      @(negedge clk);
    end
    start[s] = 1'b0;
    ready    = 1'b0;
    if (idx < stop) check("cycle_budget", 64'(idx), 64'(stop));
    if (pct == 100) check("throughput", 64'(cyc), 64'(stop));
    if (clear_after > 0) begin
      check_beat(idx);
      clear = 1'b1;
      ready = ($urandom_range(1) == 1);
      @(negedge clk);
      clear = 1'b0;
      ready = 1'b0;
      check_all_zero("clear");
      @(negedge clk);
      check("clear_no_done", 64'(m_done), 0);
      check("clear_idle", 64'(m_busy), 0);
    end else begin
      check("done_pulse", 64'(m_done), 1);
      check("done_valid", 64'(m_valid), 0);
      check("done_busy", 64'(m_busy), 1);
      if (poke) start[s] = 1'b1;
      @(negedge clk);
      start[s] = 1'b0;
      check("post_done", 64'(m_done), 0);
      check("post_busy", 64'(m_busy), 0);
      check("post_valid", 64'(m_valid), 0);
      @(negedge clk);
      check("start_not_queued", 64'(m_busy), 0);
    end
  endtask

  task automatic reset_stall();
    sel = 0;
    build(3);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    ready    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ready = 1'b0;
    check_beat(2);
    @(negedge clk);
    check_beat(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("mid_reset");
    @(negedge clk);
    check("reset_no_done", 64'(m_done), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    ready = 1'b0;
    start = '0;
    sel   = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_all_zero("reset");
    end
    rst_n = 1'b1;

    run_seq(0, 100, 0, 1'b0);
    run_seq(0, 50, 0, 1'b1);
    run_seq(0, 50, 4, 1'b0);
    run_seq(0, 100, 0, 1'b0);
    reset_stall();
    run_seq(0, 70, 0, 1'b1);
    run_seq(1, 100, 0, 1'b0);
    run_seq(1, 50, 0, 1'b1);
    run_seq(2, 100, 0, 1'b0);
    run_seq(2, 60, 0, 1'b1);
    run_seq(2, 50, 4, 1'b1);
    run_seq(2, 100, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_nest_seq.md
# loop_nest_seq

Runtime nested-loop index sequencer. It emits, as a valid/ready stream, the (outer, inner, value) tuples that our generate-unrolling flow produces statically for the two-level loop nest. Outer index `k` runs 0..NumOuter-1, the inner trip count is 2^k, and value = 2^k + l. It sits upstream of the per-iteration consumer logic and serves as the hardware golden source when checking unrolled parameter propagation.

## Interface
Parameters:
- `NumOuter`, 3, outer trip count; legal range 1..31, elaborate-time assertion otherwise.
- `OuterW`, max(1, $clog2(NumOuter)), width of outer index.
- `InnerW`, max(1, NumOuter-1), width of inner index.
- `ValueW`, 32, width of value; must be ≥ NumOuter+1.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `start_i`  in  1  begin a sequence; sampled only in IDLE.
- `clear_i`  in  1  synchronous abort; overrides `start_i`.
- `valid_o`  out  1  tuple valid.
- `ready_i`  in  1  downstream accepts tuple.
- `outer_o`  out  OuterW  current k.
- `inner_o`  out  InnerW  current l.
- `value_o`  out  ValueW  2^k + l.
- `last_inner_o`  out  1  l == 2^k − 1.
- `last_o`  out  1  final tuple of the sequence.
- `busy_o`  out  1  state != IDLE.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `start_i`=1, `clear_i`=0 → RUN. Counters load k=0, l=0, value=1.
- RUN: `valid_o`=1. On handshake (`valid_o` & `ready_i`):
  - if `last_o` → DONE;
  - else if `last_inner_o` → k+1, l=0;
  - else → l+1.
  - value increments by 1 on every handshake. The sequence is therefore 1, 2, …, 2^NumOuter − 1, and value equals beat index + 1.
- `last_o` = (k == NumOuter−1) & `last_inner_o`.
- DONE: `done_o`=1, `valid_o`=0, unconditional → IDLE.
- `clear_i`=1 in any state → IDLE next edge. Counters return to zero and no `done_o` is produced.
- `start_i` in RUN or DONE is ignored; it is not queued.
- Total beats per sequence: 2^NumOuter − 1. NumOuter=1 gives a single beat (0,0,1) with `last_inner_o`=`last_o`=1.
- Arithmetic is unsigned with no wrap: counters never exceed their final values by construction. `inner_o` upper bits are zero for small k.

## Timing
- Reset (`rst_ni`=0 at an edge): state IDLE. All outputs 0: `valid_o`, `outer_o`, `inner_o`, `value_o`, `last_inner_o`, `last_o`, `busy_o`, `done_o`. Reset mid-RUN discards the sequence with no `done_o`.
- All outputs are registered; no combinational path from `ready_i` or `start_i` to any output.
- `start_i` high at edge t → `valid_o`, `busy_o` high from t+1.
- AXI-style handshake: while `valid_o` & !`ready_i`, every payload output holds stable. `valid_o` never drops without a handshake except on `clear_i` or reset.
- Throughput: one beat per cycle with `ready_i` held high.
- Last handshake at edge t → `done_o`=1 during t+1 → IDLE at t+2. Earliest new `start_i` is sampled at edge t+2.
- `clear_i` and a handshake in the same cycle: `clear_i` wins and the beat counts as consumed by downstream.

## Test plan
- Reset then `start_i` pulse, `ready_i`=1, NumOuter=3 → 7 beats (k,l,value): (0,0,1)(1,0,2)(1,1,3)(2,0,4)(2,1,5)(2,2,6)(2,3,7). `last_inner_o` is high on values 1, 3 and 7; `last_o` only on 7; `done_o` one cycle after; then IDLE.
- Random `ready_i` backpressure at ~50% → identical tuple order. Payload is stable across every stall. `done_o` follows the final handshake by exactly 1 cycle.
- `clear_i` asserted after the 4th handshake → IDLE next cycle, no `done_o`. A fresh `start_i` restarts at (0,0,1).
- `rst_ni` low for 1 cycle during a stall → all outputs 0 the next cycle. `start_i` during RUN or DONE has no effect.
- NumOuter=1 → single beat (0,0,1) with `last_o`=1. NumOuter=5 → 31 beats with values 1..31, and `outer_o`=4 for beats 16..31.
